// File: rtl/decode_execute_reg.sv
// decode_execute_reg: two-entry decode/execute pipeline register with flush and halt tracking
module decode_execute_reg #(
  parameter int WORD_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CTRL_W  = ALUOP_W + 9
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_rdat1,
  input  logic [WORD_W-1:0] in_rdat2,
  input  logic [WORD_W-1:0] in_imm,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_rdat1,
  output logic [WORD_W-1:0] out_rdat2,
  output logic [WORD_W-1:0] out_imm,
  output logic [4:0]        out_rd,
  output logic              halted
);
  localparam int P_W = CTRL_W + 4 * WORD_W + 5;
  logic [P_W-1:0] main_q, skid_q, in_p;
  logic main_v, skid_v, halt_seen, accept, drain, take;
  assign in_p = {in_ctrl, in_pc, in_rdat1, in_rdat2, in_imm, in_rd};
  assign in_ready = !skid_v && !halt_seen && !halted;
  assign accept = in_valid && in_ready;
  assign out_valid = main_v;
  assign drain = main_v && out_ready;
  assign take = !main_v || out_ready;
  assign {out_ctrl, out_pc, out_rdat1, out_rdat2, out_imm, out_rd} = main_q;
  // main/skid entries, halt tracking; invalid entries hold zero so bubbles read as zero
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
      halt_seen <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (drain && out_ctrl[1]) halted <= 1'b1;
      if (flush) begin
        main_v    <= 1'b0;
        skid_v    <= 1'b0;
        main_q    <= '0;
        skid_q    <= '0;
        halt_seen <= 1'b0;
      end else begin
        if (take) begin
          main_v <= skid_v || accept;
          main_q <= skid_v ? skid_q : accept ? in_p : '0;
          skid_v <= 1'b0;
          skid_q <= '0;
        end else if (accept) begin
          skid_v <= 1'b1;
          skid_q <= in_p;
        end
        if (accept && in_ctrl[1]) halt_seen <= 1'b1;
      end
    end
  end
endmodule
